// File: rtl/hazard_pkg.sv
// Shared types, widths and encodings for the pipeline hazard controller.
// Optional feature macro: HAZARD_STALL_CNT_EN (adds the stall_cnt port).
package hazard_pkg;

  localparam int unsigned TNEW_W = 2;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned SRC_W  = 2;
  localparam int unsigned CNT_W  = 32;

  typedef logic [TNEW_W-1:0] tnew_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [SRC_W-1:0]  fwd_t;

  // Register 0 is hard-wired: never a read dependency, never a write target.
  localparam addr_t REG_ZERO = ADDR_W'(0);

  // D-stage operand sources.
  localparam fwd_t FWD_RF   = SRC_W'(0);
  localparam fwd_t FWD_E    = SRC_W'(1);
  localparam fwd_t FWD_M    = SRC_W'(2);
  localparam fwd_t FWD_W    = SRC_W'(3);

  // E-stage operand sources.
  localparam fwd_t FWD_EREG = SRC_W'(0);
  localparam fwd_t FWD_EM   = SRC_W'(1);
  localparam fwd_t FWD_EW   = SRC_W'(2);

  // Tracking payload carried by each pipeline stage.
  typedef struct packed {
    tnew_t tnew;
    addr_t wa;
    addr_t ra1;
    addr_t ra2;
  } stage_t;

  // Count down towards result availability, clamping at zero.
  function automatic tnew_t sat_dec(input tnew_t t);
    return (t == TNEW_W'(0)) ? TNEW_W'(0) : TNEW_W'(t - TNEW_W'(1));
  endfunction

  // Real register dependency: nonzero read address equal to the write address.
  function automatic logic addr_hit(input addr_t ra, input addr_t wa);
    return (ra != REG_ZERO) && (ra == wa);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage of hazard tracking state: tnew, destination and,
// optionally, the stage's own read addresses. tnew is decremented on load.
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter bit HAS_RA = 1'b1
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   clr,
  input  stage_t d,
  output stage_t q
);

  // Reset beats bubble insertion, bubble beats a normal load.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q.tnew <= sat_dec(d.tnew);
      q.wa   <= d.wa;
      q.ra1  <= HAS_RA ? d.ra1 : REG_ZERO;
      q.ra2  <= HAS_RA ? d.ra2 : REG_ZERO;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall and forwarding control for a 5-stage pipeline (tuse/tnew scheme).
// Optional feature macro: HAZARD_STALL_CNT_EN adds a 32-bit stall counter.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [TNEW_W-1:0] d_tuse1,
  input  logic [TNEW_W-1:0] d_tuse2,
  input  logic [ADDR_W-1:0] d_ra1,
  input  logic [ADDR_W-1:0] d_ra2,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic [ADDR_W-1:0] d_wa,
  output logic              stall,
  output logic [SRC_W-1:0]  fwd_rs_d,
  output logic [SRC_W-1:0]  fwd_rt_d,
  output logic [SRC_W-1:0]  fwd_rs_e,
  output logic [SRC_W-1:0]  fwd_rt_e
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  stage_t d_stage;
  stage_t m_d;
  stage_t w_d;
  stage_t e_q;
  stage_t m_q;
  stage_t w_q;

  // M and W never carry read addresses; their ra fields are constant zero.
  logic [4*ADDR_W-1:0] ra_unused;
  assign ra_unused = {m_q.ra1, m_q.ra2, w_q.ra1, w_q.ra2};

  // D-stage operand source: youngest matching producer wins, usable only once ready.
  function automatic fwd_t src_d(input addr_t ra,
                                 input tnew_t e_tnew, input addr_t e_wa,
                                 input tnew_t m_tnew, input addr_t m_wa,
                                 input tnew_t w_tnew, input addr_t w_wa);
    fwd_t src;
    src = FWD_RF;
    if (addr_hit(ra, e_wa)) begin
      src = (e_tnew == TNEW_W'(0)) ? FWD_E : FWD_RF;
    end else if (addr_hit(ra, m_wa)) begin
      src = (m_tnew == TNEW_W'(0)) ? FWD_M : FWD_RF;
    end else if (addr_hit(ra, w_wa)) begin
      src = (w_tnew == TNEW_W'(0)) ? FWD_W : FWD_RF;
    end
    return src;
  endfunction

  // E-stage operand source: same rule over M and W.
  function automatic fwd_t src_e(input addr_t ra,
                                 input tnew_t m_tnew, input addr_t m_wa,
                                 input tnew_t w_tnew, input addr_t w_wa);
    fwd_t src;
    src = FWD_EREG;
    if (addr_hit(ra, m_wa)) begin
      src = (m_tnew == TNEW_W'(0)) ? FWD_EM : FWD_EREG;
    end else if (addr_hit(ra, w_wa)) begin
      src = (w_tnew == TNEW_W'(0)) ? FWD_EW : FWD_EREG;
    end
    return src;
  endfunction

  // Next-stage payloads: D feeds E, E feeds M, M feeds W.
  always_comb begin
    d_stage = '{tnew: d_tnew, wa: d_wa, ra1: d_ra1, ra2: d_ra2};
    m_d     = '{tnew: e_q.tnew, wa: e_q.wa, ra1: REG_ZERO, ra2: REG_ZERO};
    w_d     = '{tnew: m_q.tnew, wa: m_q.wa, ra1: REG_ZERO, ra2: REG_ZERO};
  end

  hazard_stage_reg #(.HAS_RA(1'b1)) u_e_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (stall),
    .d       (d_stage),
    .q       (e_q)
  );

  hazard_stage_reg #(.HAS_RA(1'b0)) u_m_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .d       (m_d),
    .q       (m_q)
  );

  hazard_stage_reg #(.HAS_RA(1'b0)) u_w_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .d       (w_d),
    .q       (w_q)
  );

  // Stall when a D operand is needed before an in-flight E/M result exists.
  always_comb begin
    stall = 1'b0;
    if (addr_hit(d_ra1, e_q.wa) && (d_tuse1 < e_q.tnew)) stall = 1'b1;
    if (addr_hit(d_ra2, e_q.wa) && (d_tuse2 < e_q.tnew)) stall = 1'b1;
    if (addr_hit(d_ra1, m_q.wa) && (d_tuse1 < m_q.tnew)) stall = 1'b1;
    if (addr_hit(d_ra2, m_q.wa) && (d_tuse2 < m_q.tnew)) stall = 1'b1;
  end

  // Forwarding selects for both D and E operands.
  always_comb begin
    fwd_rs_d = src_d(d_ra1, e_q.tnew, e_q.wa, m_q.tnew, m_q.wa, w_q.tnew, w_q.wa);
    fwd_rt_d = src_d(d_ra2, e_q.tnew, e_q.wa, m_q.tnew, m_q.wa, w_q.tnew, w_q.wa);
    fwd_rs_e = src_e(e_q.ra1, m_q.tnew, m_q.wa, w_q.tnew, w_q.wa);
    fwd_rt_e = src_e(e_q.ra2, m_q.tnew, m_q.wa, w_q.tnew, w_q.wa);
  end

`ifdef HAZARD_STALL_CNT_EN
  // Count stalled cycles; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
